// File: rtl/game_pkg.sv
// Shared types and constants for the runner game: lane FSM states, step
// direction, and the default lane count used by the lane, obstacle and
// render blocks.
package game_pkg;

  localparam int unsigned DEFAULT_LANES = 3;

  typedef enum logic [1:0] {
    StIdle,
    StDelay,
    StRepeat,
    StLocked
  } lane_state_e;

  typedef enum logic {
    DirL,
    DirR
  } dir_e;

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchroniser for an asynchronous button input.
module btn_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of the raw input into the clk domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/player_lanes.sv
// Lane-position controller for the runner: synchronised left/right buttons
// step a one-hot lane vector, with hold-to-auto-repeat, optional wrap, a
// freeze enable, and moved/blocked status pulses.
module player_lanes
  import game_pkg::*;
#(
  parameter int unsigned LANES        = DEFAULT_LANES,
  parameter int unsigned START_LANE   = 1,
  parameter bit          WRAP         = 1'b0,
  parameter int unsigned REPEAT_DELAY = 25_000_000,
  parameter int unsigned REPEAT_RATE  = 10_000_000,
  parameter int unsigned IDX_W        = $clog2(LANES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btnL,
  input  logic             btnR,
  input  logic             en,
  output logic [LANES-1:0] lane,
  output logic [IDX_W-1:0] lane_idx,
  output logic             moved,
  output logic             blocked
);

  localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [IDX_W-1:0] TOP_IDX    = IDX_W'(LANES - 1);
  localparam logic [IDX_W-1:0] START_IDX  = IDX_W'(START_LANE);
  localparam logic [LANES-1:0] START_LANE_OH = {{(LANES - 1){1'b0}}, 1'b1} << START_IDX;
  // DELAY_LAST is meaningless when REPEAT_DELAY is 0; its use is guarded below.
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);
  localparam logic [CNT_W-1:0] CNT_SAT    = '1;

  logic btn_l_s, btn_r_s;

  btn_sync u_sync_l (
    .clk (clk),
    .rst (rst),
    .d   (btnL),
    .q   (btn_l_s)
  );

  btn_sync u_sync_r (
    .clk (clk),
    .rst (rst),
    .d   (btnR),
    .q   (btn_r_s)
  );

  logic l_only, r_only, conflict, none_held;
  assign l_only    = btn_l_s & ~btn_r_s;
  assign r_only    = btn_r_s & ~btn_l_s;
  assign conflict  = btn_l_s & btn_r_s;
  assign none_held = ~btn_l_s & ~btn_r_s;

  lane_state_e      state_q, state_d;
  dir_e             dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [LANES-1:0] lane_q, lane_d;
  logic             moved_q, moved_d;
  logic             blocked_q, blocked_d;
  logic             step;
  dir_e             step_dir;
  logic             held_only;

  // FSM next state: decides when a step is attempted and in which direction
  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    cnt_d     = cnt_q;
    step      = 1'b0;
    step_dir  = dir_q;
    held_only = (dir_q == DirL) ? l_only : r_only;

    if (!en) begin
      // Freeze: re-arming requires a full release once enabled again.
      state_d = StLocked;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_d = '0;
          if (conflict) begin
            state_d = StLocked;
          end else if (l_only || r_only) begin
            step     = 1'b1;
            step_dir = l_only ? DirL : DirR;
            dir_d    = step_dir;
            state_d  = StDelay;
          end
        end
        StDelay, StRepeat: begin
          if (none_held) begin
            state_d = StIdle;
          end else if (!held_only) begin
            state_d = StLocked;
          end else if (state_q == StDelay && REPEAT_DELAY != 0 && cnt_q == DELAY_LAST) begin
            step    = 1'b1;
            cnt_d   = '0;
            state_d = StRepeat;
          end else if (state_q == StRepeat && cnt_q == RATE_LAST) begin
            step  = 1'b1;
            cnt_d = '0;
          end else if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StLocked: begin
          cnt_d = '0;
          if (none_held) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Lane update: resolve a step attempt into a move (with optional wrap) or a block
  always_comb begin
    idx_d     = idx_q;
    moved_d   = 1'b0;
    blocked_d = 1'b0;
    if (step) begin
      if (step_dir == DirL) begin
        if (idx_q == TOP_IDX) begin
          if (WRAP) begin
            idx_d   = '0;
            moved_d = 1'b1;
          end else begin
            blocked_d = 1'b1;
          end
        end else begin
          idx_d   = idx_q + 1'b1;
          moved_d = 1'b1;
        end
      end else begin
        if (idx_q == '0) begin
          if (WRAP) begin
            idx_d   = TOP_IDX;
            moved_d = 1'b1;
          end else begin
            blocked_d = 1'b1;
          end
        end else begin
          idx_d   = idx_q - 1'b1;
          moved_d = 1'b1;
        end
      end
    end
    lane_d = {{(LANES - 1){1'b0}}, 1'b1} << idx_d;
  end

  // State, counter, position and pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      dir_q     <= DirL;
      cnt_q     <= '0;
      idx_q     <= START_IDX;
      lane_q    <= START_LANE_OH;
      moved_q   <= 1'b0;
      blocked_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      lane_q    <= lane_d;
      moved_q   <= moved_d;
      blocked_q <= blocked_d;
    end
  end

  assign lane     = lane_q;
  assign lane_idx = idx_q;
  assign moved    = moved_q;
  assign blocked  = blocked_q;

endmodule

// File: tb/tb_player_lanes.sv
// Bench for player_lanes: a 3-lane blocking instance and a 5-lane wrapping
// instance share the same stimulus. A directed table drives the 3-lane
// instance; a hold-length reference model checks both every cycle.
module tb_player_lanes;

  localparam int unsigned RD = 4;
  localparam int unsigned RR = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btnL = 1'b0;
  logic btnR = 1'b0;
  logic en = 1'b1;

  logic [2:0] lane_a;
  logic [1:0] idx_a;
  logic       moved_a, blocked_a;
  logic [4:0] lane_b;
  logic [2:0] idx_b;
  logic       moved_b, blocked_b;

  player_lanes #(
    .LANES        (3),
    .START_LANE   (1),
    .WRAP         (1'b0),
    .REPEAT_DELAY (RD),
    .REPEAT_RATE  (RR)
  ) dut_a (
    .clk      (clk),
    .rst      (rst),
    .btnL     (btnL),
    .btnR     (btnR),
    .en       (en),
    .lane     (lane_a),
    .lane_idx (idx_a),
    .moved    (moved_a),
    .blocked  (blocked_a)
  );

  player_lanes #(
    .LANES        (5),
    .START_LANE   (4),
    .WRAP         (1'b1),
    .REPEAT_DELAY (RD),
    .REPEAT_RATE  (RR)
  ) dut_b (
    .clk      (clk),
    .rst      (rst),
    .btnL     (btnL),
    .btnR     (btnR),
    .en       (en),
    .lane     (lane_b),
    .lane_idx (idx_b),
    .moved    (moved_b),
    .blocked  (blocked_b)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Behaviour in terms of how long a single button has been held since its
  // first step: steps at hold 0, RD, RD+RR, RD+2RR, ...
  int m_lanes[2] = '{3, 5};
  int m_start[2] = '{1, 4};
  bit m_wrap[2]  = '{1'b0, 1'b1};
  int m_idx[2];
  int m_held[2];  // 0 none, 1 left, 2 right
  int m_len[2];
  bit m_locked[2];
  bit m_moved[2];
  bit m_blocked[2];
  bit past_l[2];  // raw samples from one and two edges ago
  bit past_r[2];

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_idx[k]     = m_start[k];
      m_held[k]    = 0;
      m_len[k]     = 0;
      m_locked[k]  = 1'b0;
      m_moved[k]   = 1'b0;
      m_blocked[k] = 1'b0;
      past_l[k]    = 1'b0;
      past_r[k]    = 1'b0;
    end
  endfunction

  function automatic void model_attempt(int k, int dir);
    int top = m_lanes[k] - 1;
    if (dir == 1) begin
      if (m_idx[k] == top) begin
        if (m_wrap[k]) begin m_idx[k] = 0; m_moved[k] = 1'b1; end
        else m_blocked[k] = 1'b1;
      end else begin
        m_idx[k]++; m_moved[k] = 1'b1;
      end
    end else begin
      if (m_idx[k] == 0) begin
        if (m_wrap[k]) begin m_idx[k] = top; m_moved[k] = 1'b1; end
        else m_blocked[k] = 1'b1;
      end else begin
        m_idx[k]--; m_moved[k] = 1'b1;
      end
    end
  endfunction

  function automatic void model_edge();
    bit sl, sr, same;
    if (rst) begin
      model_reset();
      return;
    end
    sl = past_l[1];
    sr = past_r[1];
    past_l[1] = past_l[0]; past_l[0] = btnL;
    past_r[1] = past_r[0]; past_r[0] = btnR;
    for (int k = 0; k < 2; k++) begin
      m_moved[k]   = 1'b0;
      m_blocked[k] = 1'b0;
      if (!en) begin
        m_locked[k] = 1'b1;
        m_held[k]   = 0;
      end else if (m_locked[k]) begin
        if (!sl && !sr) m_locked[k] = 1'b0;
      end else if (m_held[k] == 0) begin
        if (sl && sr) m_locked[k] = 1'b1;
        else if (sl) begin m_held[k] = 1; m_len[k] = 0; model_attempt(k, 1); end
        else if (sr) begin m_held[k] = 2; m_len[k] = 0; model_attempt(k, 2); end
      end else begin
        same = (m_held[k] == 1) ? (sl && !sr) : (sr && !sl);
        if (!sl && !sr) m_held[k] = 0;
        else if (!same) begin m_locked[k] = 1'b1; m_held[k] = 0; end
        else begin
          m_len[k]++;
          if (RD != 0 && (m_len[k] == int'(RD) ||
              (m_len[k] > int'(RD) && (m_len[k] - int'(RD)) % int'(RR) == 0)))
            model_attempt(k, m_held[k]);
        end
      end
    end
  endfunction

  task automatic compare_model();
    check("a_lane", 32'(lane_a), 32'(1) << m_idx[0]);
    check("a_idx", 32'(idx_a), 32'(m_idx[0]));
    check("a_moved", 32'(moved_a), 32'(m_moved[0]));
    check("a_blocked", 32'(blocked_a), 32'(m_blocked[0]));
    check("b_lane", 32'(lane_b), 32'(1) << m_idx[1]);
    check("b_idx", 32'(idx_b), 32'(m_idx[1]));
    check("b_moved", 32'(moved_b), 32'(m_moved[1]));
    check("b_blocked", 32'(blocked_b), 32'(m_blocked[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  // ---------------- directed table (3-lane instance) ----------------
  typedef struct {
    bit l;
    bit r;
    bit e;
    int idx;
    bit mv;
    bit bl;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit l, input bit r, input bit e, input int idx, input bit mv,
                     input bit bl);
    vec_t v;
    v.l = l; v.r = r; v.e = e; v.idx = idx; v.mv = mv; v.bl = bl;
    vecs.push_back(v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sel, len;

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_lane_a", 32'(lane_a), 32'h2);
    check("rst_idx_a", 32'(idx_a), 32'd1);
    check("rst_moved_a", 32'(moved_a), 32'd0);
    check("rst_blocked_a", 32'(blocked_a), 32'd0);
    check("rst_lane_b", 32'(lane_b), 32'h10);
    rst = 1'b0;

    // press L, single step, then release
    add(1, 0, 1, 1, 0, 0); add(1, 0, 1, 1, 0, 0); add(0, 0, 1, 2, 1, 0);
    add(0, 0, 1, 2, 0, 0); add(0, 0, 1, 2, 0, 0);
    // hold R: step, step after delay, then blocked on the repeat rate
    add(0, 1, 1, 2, 0, 0); add(0, 1, 1, 2, 0, 0); add(0, 1, 1, 1, 1, 0);
    add(0, 1, 1, 1, 0, 0); add(0, 1, 1, 1, 0, 0); add(0, 1, 1, 1, 0, 0);
    add(0, 1, 1, 0, 1, 0); add(0, 1, 1, 0, 0, 0); add(0, 1, 1, 0, 0, 1);
    add(0, 0, 1, 0, 0, 0); add(0, 0, 1, 0, 0, 1); add(0, 0, 1, 0, 0, 0);
    // hold L, add R (conflict lock), drop R with L held, release, re-press
    add(1, 0, 1, 0, 0, 0); add(1, 0, 1, 0, 0, 0); add(1, 1, 1, 1, 1, 0);
    add(1, 1, 1, 1, 0, 0); add(1, 0, 1, 1, 0, 0); add(1, 0, 1, 1, 0, 0);
    add(0, 0, 1, 1, 0, 0); add(0, 0, 1, 1, 0, 0); add(1, 0, 1, 1, 0, 0);
    add(0, 0, 1, 1, 0, 0); add(0, 0, 1, 2, 1, 0);
    // en=0 for one cycle then R held: locked until released
    add(0, 1, 1, 2, 0, 0); add(0, 1, 0, 2, 0, 0); add(0, 1, 1, 2, 0, 0);
    add(0, 1, 1, 2, 0, 0); add(0, 0, 1, 2, 0, 0); add(0, 0, 1, 2, 0, 0);
    add(0, 1, 1, 2, 0, 0); add(0, 0, 1, 2, 0, 0); add(0, 0, 1, 1, 1, 0);
    add(0, 0, 1, 1, 0, 0);
    // en=0 while L is held, en=1 with L still held, release, re-press
    add(1, 0, 1, 1, 0, 0); add(1, 0, 1, 1, 0, 0); add(1, 0, 0, 1, 0, 0);
    add(1, 0, 0, 1, 0, 0); add(1, 0, 1, 1, 0, 0); add(1, 0, 1, 1, 0, 0);
    add(0, 0, 1, 1, 0, 0); add(0, 0, 1, 1, 0, 0); add(1, 0, 1, 1, 0, 0);
    add(0, 0, 1, 1, 0, 0); add(0, 0, 1, 2, 1, 0); add(0, 0, 1, 2, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      btnL = vecs[i].l;
      btnR = vecs[i].r;
      en   = vecs[i].e;
      tick();
      check($sformatf("tbl%0d_idx", i), 32'(idx_a), 32'(vecs[i].idx));
      check($sformatf("tbl%0d_lane", i), 32'(lane_a), 32'(1) << vecs[i].idx);
      check($sformatf("tbl%0d_moved", i), 32'(moved_a), 32'(vecs[i].mv));
      check($sformatf("tbl%0d_blocked", i), 32'(blocked_a), 32'(vecs[i].bl));
      if (i == 2) begin
        // 5-lane wrapping instance: leftmost lane stepping left lands on lane 0
        check("wrap_lane_b", 32'(lane_b), 32'h01);
        check("wrap_moved_b", 32'(moved_b), 32'd1);
      end
    end

    // reset asserted mid auto-repeat with R held at the right edge
    btnL = 1'b0; btnR = 1'b1; en = 1'b1;
    repeat (11) tick();
    rst = 1'b1;
    #1;
    check("midrst_lane_a", 32'(lane_a), 32'h2);
    check("midrst_idx_a", 32'(idx_a), 32'd1);
    check("midrst_moved_a", 32'(moved_a), 32'd0);
    check("midrst_blocked_a", 32'(blocked_a), 32'd0);
    check("midrst_lane_b", 32'(lane_b), 32'h10);
    model_reset();
    tick();
    rst = 1'b0;
    repeat (6) tick();
    btnR = 1'b0;
    repeat (4) tick();

    // randomized hold patterns, enables and occasional resets
    for (int run = 0; run < 300; run++) begin
      sel = $urandom_range(0, 9);
      btnL = (sel <= 3) || (sel == 7);
      btnR = (sel >= 4 && sel <= 7);
      en   = ($urandom_range(0, 15) != 0);
      len  = $urandom_range(1, 14);
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        model_reset();
        tick();
        rst = 1'b0;
      end
      repeat (len) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
